// File: rtl/alu181_pkg.sv
// Shared types and 74181 function-select constants for the serial ALU.
package alu181_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // S_SUB and S_XOR share an encoding; m selects arithmetic vs logic
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/alu181_if.sv
// Operation/result handshake bundle for alu181_serial.
interface alu181_if #(parameter int WIDTH = 16);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       s;
  logic             m, cin, acc_sel;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] f;
  logic             cout, zero, aeqb;

  modport master (output in_valid, a, b, s, m, cin, acc_sel, out_ready,
                  input  in_ready, out_valid, f, cout, zero, aeqb);
  modport slave  (input  in_valid, a, b, s, m, cin, acc_sel, out_ready,
                  output in_ready, out_valid, f, cout, zero, aeqb);
endinterface

// File: rtl/alu181_slice.sv
// Combinational SLICE-bit 74181 cell; carry-out forced low in logic mode.
module alu181_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic [3:0]       i_s,
  input  logic             i_m,
  input  logic             i_c,
  output logic [SLICE-1:0] o_f,
  output logic             o_c
);
  logic [SLICE-1:0] w_t1, w_t2;
  logic [SLICE:0]   w_sum;

  assign w_t1  = i_a | (i_b & {SLICE{i_s[0]}}) | (~i_b & {SLICE{i_s[1]}});
  assign w_t2  = (i_a & ~i_b & {SLICE{i_s[2]}}) | (i_a & i_b & {SLICE{i_s[3]}});
  assign w_sum = {1'b0, w_t1} + {1'b0, w_t2} + {{SLICE{1'b0}}, i_c};
  assign o_f   = i_m ? ~(w_t1 ^ w_t2) : w_sum[SLICE-1:0];
  assign o_c   = ~i_m & w_sum[SLICE];
endmodule

// File: rtl/alu181_serial.sv
// Multi-cycle 74181 ALU: one slice per cycle, LSB first, registered ripple carry.
// Optional accumulator operand enabled by defining ALU181_ACC_EN.
module alu181_serial
  import alu181_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  alu181_if.slave  bus
);
  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_f;
  logic [3:0]       r_s;
  logic             r_m, r_c, r_cout, r_zero, r_aeqb, r_out_valid;
  logic [CW-1:0]    r_k;

  logic [WIDTH-1:0] w_a_in, w_f_next;
  logic [SLICE-1:0] w_f_sl;
  logic             w_c_sl, w_last;

`ifdef ALU181_ACC_EN
  logic [WIDTH-1:0] r_acc;
  assign w_a_in = bus.acc_sel ? r_acc : bus.a;
`else
  logic w_unused_acc_sel;
  assign w_unused_acc_sel = bus.acc_sel;
  assign w_a_in = bus.a;
`endif

  alu181_slice #(.SLICE(SLICE)) u_slice (
    .i_a (r_a[r_k*SLICE +: SLICE]),
    .i_b (r_b[r_k*SLICE +: SLICE]),
    .i_s (r_s),
    .i_m (r_m),
    .i_c (r_c),
    .o_f (w_f_sl),
    .o_c (w_c_sl)
  );

  // Full result including the slice being written, so flags register with it
  always_comb begin
    w_f_next = r_f;
    w_f_next[r_k*SLICE +: SLICE] = w_f_sl;
  end

  assign w_last = (r_k == CW'(NSL-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_m         <= 1'b0;
      r_c         <= 1'b0;
      r_k         <= '0;
      r_f         <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_aeqb      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ALU181_ACC_EN
      r_acc       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a     <= w_a_in;
          r_b     <= bus.b;
          r_s     <= bus.s;
          r_m     <= bus.m;
          r_c     <= bus.cin;
          r_k     <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_f <= w_f_next;
          r_c <= w_c_sl;
          if (w_last) begin
            r_cout      <= w_c_sl;
            r_zero      <= (w_f_next == '0);
            r_aeqb      <= &w_f_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
`ifdef ALU181_ACC_EN
          r_acc       <= r_f;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.f         = r_f;
  assign bus.cout      = r_cout;
  assign bus.zero      = r_zero;
  assign bus.aeqb      = r_aeqb;
endmodule

// File: tb/tb_alu181_serial.sv
// Directed + scoreboard bench for alu181_serial (WIDTH=16, SLICE=4).
module tb_alu181_serial;
  import alu181_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu181_if #(.WIDTH(16)) bus();
  alu181_serial #(.WIDTH(16), .SLICE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed { logic [15:0] f; logic cout; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, b, input logic [3:0] s,
                                 input logic m, cin);
    logic [15:0] t1, t2;
    logic [16:0] sum;
    exp_t e;
    t1 = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
    t2 = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
    sum = {1'b0, t1} + {1'b0, t2} + {16'd0, cin};
    if (m) begin e.f = ~(t1 ^ t2); e.cout = 1'b0; end
    else   begin e.f = sum[15:0];  e.cout = sum[16]; end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge out_valid is seen
  task automatic send(input string tag, input logic [15:0] a, b, input logic [3:0] s,
                      input logic m, cin, acc, input exp_t e);
    int lat;
    chk({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.s = s; bus.m = m; bus.cin = cin; bus.acc_sel = acc;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = ~cin; bus.s = ~s;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, "/latency"}, 32'(lat), 32'd4);
  endtask

  task automatic recv(input string tag, input bit pre_ready);
    exp_t e;
    e = '0;
    chk({tag, "/sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "/f"},    32'(bus.f),    32'(e.f));
    chk({tag, "/cout"}, 32'(bus.cout), 32'(e.cout));
    chk({tag, "/zero"}, 32'(bus.zero), 32'(e.f == 16'h0));
    chk({tag, "/aeqb"}, 32'(bus.aeqb), 32'(&e.f));
    if (!pre_ready) bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "/ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "/idle"},    32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    bit rose;
    exp_t e;
    logic [15:0] ra, rb;
    logic [3:0]  rs;
    logic        rm, rc;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0;
    bus.cin = 1'b0; bus.acc_sel = 1'b0; bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst/in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst/f",         32'(bus.f),         32'd0);
    chk("rst/flags",     32'({bus.cout, bus.zero, bus.aeqb}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send("add1", 16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b0, 1'b0, '{16'h2233, 1'b0});
    recv("add1", 1'b0);
    send("add2", 16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b0, 1'b0, '{16'h0000, 1'b1});
    recv("add2", 1'b0);
    send("sub0", 16'h0005, 16'h0005, S_SUB, 1'b0, 1'b0, 1'b0, '{16'hFFFF, 1'b0});
    recv("sub0", 1'b0);
    send("sub1", 16'h0005, 16'h0005, S_SUB, 1'b0, 1'b1, 1'b0, '{16'h0000, 1'b1});
    recv("sub1", 1'b0);

    // Stall in DONE with a competing request that must be dropped
    send("xor", 16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b0, 1'b0, '{16'h0FF0, 1'b0});
    bus.a = 16'h1111; bus.b = 16'h2222; bus.s = S_ADD; bus.m = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold/f",         32'(bus.f),         32'h0FF0);
      chk("hold/out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold/in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    recv("xor", 1'b0);
    rose = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.out_valid) rose = 1'b1; end
    chk("noqueue/out_valid", 32'(rose), 32'd0);

    // Consumer already ready: out_valid lasts one cycle
    bus.out_ready = 1'b1;
    send("rdy", 16'h0100, 16'h00FF, S_ADD, 1'b0, 1'b1, 1'b0, '{16'h0200, 1'b0});
    recv("rdy", 1'b1);

    // Reset in the middle of RUN
    bus.a = 16'h5555; bus.b = 16'h1111; bus.s = S_ADD; bus.m = 1'b0; bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst/out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst/in_ready",  32'(bus.in_ready),  32'd1);
    chk("mrst/f",         32'(bus.f),         32'd0);
    chk("mrst/flags",     32'({bus.cout, bus.zero, bus.aeqb}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.out_valid) rose = 1'b1; end
    chk("mrst/no_result", 32'(rose), 32'd0);
    send("post", 16'h0001, 16'h0001, S_ADD, 1'b0, 1'b0, 1'b0, '{16'h0002, 1'b0});
    recv("post", 1'b0);

    send("acc0", 16'h0010, 16'h0001, S_ADD, 1'b0, 1'b0, 1'b0, '{16'h0011, 1'b0});
    recv("acc0", 1'b0);
`ifdef ALU181_ACC_EN
    send("acc1", 16'h0030, 16'h0001, S_ADD, 1'b0, 1'b0, 1'b1, '{16'h0012, 1'b0});
`else
    send("acc1", 16'h0030, 16'h0001, S_ADD, 1'b0, 1'b0, 1'b1, '{16'h0031, 1'b0});
`endif
    recv("acc1", 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 4'($urandom_range(0, 15)); rm = 1'($urandom); rc = 1'($urandom);
      e = model(ra, rb, rs, rm, rc);
      send("rnd", ra, rb, rs, rm, rc, 1'b0, e);
      recv("rnd", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/alu181_serial.md
# alu181_serial

- Parametrised, multi-cycle 74181-function ALU.
- Accepts one WIDTH-bit operation through a valid/ready handshake and evaluates it SLICE bits per cycle, least-significant slice first, using a registered ripple carry.
- Presents the result and flags through a second valid/ready handshake.
- Successor to the fixed 8-bit combinational adder top. It sits behind the top-level pin wrapper, which feeds it operands and drains results.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits evaluated per cycle; NSL = WIDTH/SLICE ≥ 1.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- a, b  in  WIDTH  operands.
- s  in  4  74181 function select.
- m  in  1  1 = logic, 0 = arithmetic.
- cin  in  1  carry-in, active high (+1).
- acc_sel  in  1  use accumulator as A (only with ALU181_ACC_EN).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- f  out  WIDTH  result.
- cout  out  1  carry out of MSB, arithmetic only, else 0.
- zero  out  1  f == 0.
- aeqb  out  1  f all ones (74181 A=B).

## Operation
- Per-bit terms:
  - T1 = a | (b & s[0]) | (~b & s[1])
  - T2 = (a & ~b & s[2]) | (a & b & s[3])
- Arithmetic (m=0): f = T1 + T2 + cin, modulo 2^WIDTH; cout = bit WIDTH of the sum.
- Logic (m=1): f = ~(T1 ^ T2), bitwise; no carry; cout = 0.
- FSM states:
  - IDLE: in_ready=1. When in_valid is high, capture a, b, s, m, cin (and acc_sel), clear slice counter, load carry register with cin, go to RUN.
  - RUN: each cycle compute slice k from the registered operands and carry register. Write the slice into f[k*SLICE +: SLICE] and update the carry register. When k == NSL-1, go to DONE; otherwise k+1.
  - DONE: out_valid=1; f, cout, zero and aeqb are stable. When out_ready is high, go to IDLE.
- Operand inputs are sampled only on the accept edge. Later changes on the inputs are ignored.
- in_ready is low in RUN and DONE; in_valid in those states is ignored, with no queueing.
- Reset (async, any state): go to IDLE; f, cout, zero, aeqb, out_valid, the counter, the carry register and the accumulator all go to 0. An operation interrupted by reset is dropped and never produces out_valid.
- zero and aeqb are derived from the full registered f and are meaningful only while out_valid is high.

## Timing
- Accept on edge E.
- Slices are computed on edges E+1 … E+NSL; out_valid is high after edge E+NSL.
- Latency is NSL cycles from accept to out_valid.
- Minimum issue interval is NSL+2 cycles: DONE→IDLE takes one edge, and the next accept needs one more.
- NSL=1 (SLICE=WIDTH): single RUN cycle; must work.
- out_ready held low: DONE persists indefinitely, outputs unchanged.
- out_ready already high on entry to DONE: out_valid is high for exactly one cycle.
- No combinational path from any input to any output except in_ready, which depends on state only.

## Configuration
- Macro: ALU181_ACC_EN.
- Defined:
  - A WIDTH-bit accumulator loads f on every result handshake (out_valid & out_ready).
  - On accept with acc_sel=1, the accumulator replaces a as operand A.
- Undefined:
  - No accumulator register.
  - acc_sel is present but ignored; a is always used.

## Structure
- Package alu181_pkg holds the FSM state enum (IDLE, RUN, DONE) and the 4-bit function-select constants, e.g. S_ADD=4'b1001, S_SUB=4'b0110, S_XOR=4'b0110 with m=1.
- Sub-module alu181_slice: combinational, parametrised by SLICE.
  - Inputs: a/b slice, s, m, carry-in.
  - Outputs: f slice and carry-out.
  - Instantiated once and time-multiplexed by the counter.

## Test plan
All with WIDTH=16, SLICE=4.
- m=0, s=1001, cin=0, a=0x1234, b=0x0FFF → f=0x2233, cout=0, zero=0, out_valid exactly 4 cycles after accept.
- m=0, s=1001, cin=0, a=0xFFFF, b=0x0001 → f=0x0000, cout=1, zero=1; carry ripples through all four slices.
- m=0, s=0110, cin=0, a=b=0x0005 → f=0xFFFF, aeqb=1, cout=0.
  - Same with cin=1 → f=0x0000, cout=1, zero=1.
- m=1, s=0110, a=0xF0F0, b=0xFF00 → f=0x0FF0, cout=0.
  - Then hold out_ready=0 for 5 cycles → f is stable, in_ready=0, a concurrent in_valid is ignored.
- Assert rst_n low after 2 RUN cycles → out_valid never rises; all outputs 0; in_ready=1.
  - A fresh op a=1, b=1, s=1001 then yields f=0x0002.
- With ALU181_ACC_EN: a=0x0010 + b=0x0001 (s=1001) completes, then acc_sel=1, b=0x0001 → f=0x0012.
  - Without the macro, the second op gives a + 1.
